// File: rtl/barrier_controller.sv
// Barrier responder: tracks per-(block, barrier) warp arrivals in NUM_SLOTS slots
// and offers one release at a time carrying the slot's expected warp mask.
module barrier_controller #(
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] barrier_id,
  input  logic [31:0] thread_mask,
  input  logic [9:0]  block_id,
  input  logic [5:0]  warp_id,
  input  logic [31:0] expected_mask,
  input  logic        request_valid,
  output logic        ready,
  output logic [15:0] release_barrier_id,
  output logic [9:0]  release_block_id,
  output logic [31:0] release_warp_mask,
  output logic        release_valid,
  input  logic        release_ready,
  output logic        stall,
  output logic [31:0] stall_warp_mask,
  output logic        err
);
  localparam int unsigned IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [1:0] S_FREE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]    r_state [NUM_SLOTS];
  logic [15:0]   r_bid   [NUM_SLOTS];
  logic [9:0]    r_blk   [NUM_SLOTS];
  logic [31:0]   r_exp   [NUM_SLOTS];
  logic [31:0]   r_arr   [NUM_SLOTS];
  logic          r_out_busy;
  logic [IW-1:0] r_out_idx;
  logic          r_err;

  logic          w_match, w_free, w_rel_any;
  logic [IW-1:0] w_match_idx, w_free_idx, w_rel_idx;
  logic [31:0]   w_stall_mask, w_warp_bit, w_upd_arr;
  logic          w_bad, w_accept, w_handshake;

  // Each search keeps the lowest-index hit.
  always_comb begin
    w_match      = 1'b0;
    w_match_idx  = '0;
    w_free       = 1'b0;
    w_free_idx   = '0;
    w_rel_any    = 1'b0;
    w_rel_idx    = '0;
    w_stall_mask = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!w_match && r_state[i] == S_COLLECT &&
          r_bid[i] == barrier_id && r_blk[i] == block_id) begin
        w_match     = 1'b1;
        w_match_idx = IW'(i);
      end
      if (!w_free && r_state[i] == S_FREE) begin
        w_free     = 1'b1;
        w_free_idx = IW'(i);
      end
      if (!w_rel_any && r_state[i] == S_RELEASE) begin
        w_rel_any = 1'b1;
        w_rel_idx = IW'(i);
      end
      if (r_state[i] != S_FREE) w_stall_mask = w_stall_mask | r_arr[i];
    end
    w_warp_bit = 32'd1 << warp_id[4:0];
    w_upd_arr  = r_arr[w_match_idx] | w_warp_bit;
    if (warp_id[5] || thread_mask == '0)
      w_bad = 1'b1;
    else if (w_match)
      w_bad = ((r_exp[w_match_idx] & w_warp_bit) == '0) ||
              ((r_arr[w_match_idx] & w_warp_bit) != '0);
    else
      w_bad = (expected_mask == '0) || ((expected_mask & w_warp_bit) == '0);
  end

  assign ready       = !rst && (w_match || w_free);
  assign w_accept    = request_valid && ready;
  assign w_handshake = r_out_busy && release_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= S_FREE;
        r_bid[i]   <= '0;
        r_blk[i]   <= '0;
        r_exp[i]   <= '0;
        r_arr[i]   <= '0;
      end
      r_out_busy <= 1'b0;
      r_out_idx  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_accept && w_bad;
      if (w_handshake) begin
        r_state[r_out_idx] <= S_FREE;
        r_bid[r_out_idx]   <= '0;
        r_blk[r_out_idx]   <= '0;
        r_exp[r_out_idx]   <= '0;
        r_arr[r_out_idx]   <= '0;
        r_out_busy         <= 1'b0;
      end else if (!r_out_busy && w_rel_any) begin
        r_out_busy <= 1'b1;
        r_out_idx  <= w_rel_idx;
      end
      // The handshake slot is in RELEASE, so it never collides with the arrival slot.
      if (w_accept && !w_bad) begin
        if (w_match) begin
          r_arr[w_match_idx] <= w_upd_arr;
          if (w_upd_arr == r_exp[w_match_idx]) r_state[w_match_idx] <= S_RELEASE;
        end else begin
          r_arr[w_free_idx]   <= w_warp_bit;
          r_exp[w_free_idx]   <= expected_mask;
          r_bid[w_free_idx]   <= barrier_id;
          r_blk[w_free_idx]   <= block_id;
          r_state[w_free_idx] <= (w_warp_bit == expected_mask) ? S_RELEASE : S_COLLECT;
        end
      end
    end
  end

  assign release_valid      = !rst && r_out_busy;
  assign release_barrier_id = release_valid ? r_bid[r_out_idx] : '0;
  assign release_block_id   = release_valid ? r_blk[r_out_idx] : '0;
  assign release_warp_mask  = release_valid ? r_exp[r_out_idx] : '0;
  assign stall_warp_mask    = rst ? '0 : w_stall_mask;
  assign stall              = |stall_warp_mask;
  assign err                = !rst && r_err;
endmodule
